// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operand word counts, load-sequencer state encoding
// and the accumulator count.
package fpu_pkg;

    localparam logic [2:0] FP_NW_IMM = 3'd1;
    localparam logic [2:0] FP_NW_F   = 3'd2;
    localparam logic [2:0] FP_NW_D   = 3'd4;

    localparam logic [2:0] FP_NREGS  = 3'd6;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;

    function automatic logic [2:0] fp_nwords(input logic fpmode, input logic imm);
        if (imm) begin
            return FP_NW_IMM;
        end
        return fpmode ? FP_NW_D : FP_NW_F;
    endfunction

endpackage

// File: rtl/fpu_opload.sv
// FPU operand-load sequencer: gathers 1, 2 or 4 memory words MSW-first and
// issues one write strobe to the accumulator register file.
module fpu_opload
    import fpu_pkg::*;
#(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned REG_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              fpmode,
    input  logic              imm,
    input  logic [2:0]        dst,
    input  logic              abort,
    input  logic [WORD_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic [2:0]        waddr,
    output logic [REG_W-1:0]  d,
    output logic              we,
    output logic              done,
    output logic              err,
    output logic              busy
);

    logic [1:0]       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [1:0]       last_q, last_d;
    logic [2:0]       dst_q, dst_d;
    logic [REG_W-1:0] buf_q, buf_d;
    logic [REG_W-1:0] d_q, d_d;
    logic [2:0]       waddr_q, waddr_d;
    logic [2:0]       nw_m1;
    logic             legal;
    logic             accept;

    assign legal  = (dst_q < FP_NREGS);
    assign wready = (state_q == ST_COLLECT) && !abort;
    assign accept = wvalid && wready;
    assign busy   = (state_q != ST_IDLE);

    // abort outranks the write strobe even in the WRITE cycle itself
    assign we     = (state_q == ST_WRITE) && !abort && legal;
    assign err    = (state_q == ST_WRITE) && !abort && !legal;
    assign done   = we || err;

    assign d      = d_q;
    assign waddr  = waddr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        dst_d   = dst_q;
        buf_d   = buf_q;
        d_d     = d_q;
        waddr_d = waddr_q;
        nw_m1   = fp_nwords(fpmode, imm) - 3'd1;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_COLLECT;
                    last_d  = nw_m1[1:0];
                    dst_d   = dst;
                    cnt_d   = 2'd0;
                    buf_d   = '0;
                end
            end
            ST_COLLECT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    // word k lands at bit (3-k)*16, i.e. {~k, 4'b0}
                    buf_d[{~cnt_q, 4'b0000} +: WORD_W] = wdata;
                    if (cnt_q == last_q) begin
                        state_d = ST_WRITE;
                        cnt_d   = 2'd0;
                        if (legal) begin
                            d_d     = buf_d;
                            waddr_d = dst_q;
                        end
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            last_q  <= 2'd0;
            dst_q   <= 3'd0;
            buf_q   <= '0;
            d_q     <= '0;
            waddr_q <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            dst_q   <= dst_d;
            buf_q   <= buf_d;
            d_q     <= d_d;
            waddr_q <= waddr_d;
        end
    end

endmodule

// File: tb/tb_fpu_opload.sv
// Directed bench for fpu_opload: hand-computed operand images, latency,
// illegal destinations, abort and reset behaviour.
module tb_fpu_opload;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        fpmode;
    logic        imm;
    logic [2:0]  dst;
    logic        abort;
    logic [15:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [2:0]  waddr;
    logic [63:0] d;
    logic        we;
    logic        done;
    logic        err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    fpu_opload dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .fpmode (fpmode),
        .imm    (imm),
        .dst    (dst),
        .abort  (abort),
        .wdata  (wdata),
        .wvalid (wvalid),
        .wready (wready),
        .waddr  (waddr),
        .d      (d),
        .we     (we),
        .done   (done),
        .err    (err),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic fm, input logic im, input logic [2:0] ds);
        start  = 1'b1;
        fpmode = fm;
        imm    = im;
        dst    = ds;
        #3;
        check("busy_at_start", {63'd0, busy}, 64'd0);
        next_cycle();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        wvalid = 1'b1;
        wdata  = w;
        #3;
        check("wready_collect", {63'd0, wready}, 64'd1);
        check("busy_collect", {63'd0, busy}, 64'd1);
        check("no_we_collect", {63'd0, we}, 64'd0);
        next_cycle();
        wvalid = 1'b0;
    endtask

    task automatic expect_write(input logic [2:0] ds, input logic [63:0] val);
        #3;
        check("we", {63'd0, we}, 64'd1);
        check("done", {63'd0, done}, 64'd1);
        check("err_clear", {63'd0, err}, 64'd0);
        check("wready_write", {63'd0, wready}, 64'd0);
        check("waddr", {61'd0, waddr}, {61'd0, ds});
        check("d", d, val);
        next_cycle();
        #3;
        check("idle_after_write", {63'd0, busy}, 64'd0);
        check("we_one_cycle", {63'd0, we}, 64'd0);
        check("d_holds", d, val);
    endtask

    task automatic expect_err();
        #3;
        check("err", {63'd0, err}, 64'd1);
        check("err_done", {63'd0, done}, 64'd1);
        check("err_no_we", {63'd0, we}, 64'd0);
        next_cycle();
        #3;
        check("idle_after_err", {63'd0, busy}, 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_wready"}, {63'd0, wready}, 64'd0);
        check({tag, "_we"}, {63'd0, we}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
        check({tag, "_err"}, {63'd0, err}, 64'd0);
        check({tag, "_d"}, d, 64'd0);
        check({tag, "_waddr"}, {61'd0, waddr}, 64'd0);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        fpmode = 1'b0;
        imm    = 1'b0;
        dst    = 3'd0;
        abort  = 1'b0;
        wdata  = 16'h0000;
        wvalid = 1'b0;
        next_cycle();
        next_cycle();
        check_all_zero("reset");
        reset = 1'b0;
        next_cycle();

        // D load, back-to-back words: we lands in cycle 5
        start_load(1'b1, 1'b0, 3'd2);
        send_word(16'h4080);
        send_word(16'h1111);
        send_word(16'h2222);
        send_word(16'h3333);
        expect_write(3'd2, 64'h4080_1111_2222_3333);

        // F load with a 3-cycle stall between words
        start_load(1'b0, 1'b0, 3'd5);
        send_word(16'hC1A0);
        for (int i = 0; i < 3; i++) begin
            #3;
            check("stall_busy", {63'd0, busy}, 64'd1);
            check("stall_no_we", {63'd0, we}, 64'd0);
            next_cycle();
        end
        send_word(16'h0001);
        expect_write(3'd5, 64'hC1A0_0001_0000_0000);

        // Immediate, fpmode=1: one word only
        start_load(1'b1, 1'b1, 3'd0);
        send_word(16'h4120);
        expect_write(3'd0, 64'h4120_0000_0000_0000);

        // Illegal destinations
        start_load(1'b0, 1'b0, 3'd6);
        send_word(16'h1234);
        send_word(16'h5678);
        expect_err();
        start_load(1'b0, 1'b0, 3'd7);
        send_word(16'h9ABC);
        send_word(16'hDEF0);
        expect_err();
        #3;
        check("err_keeps_d", d, 64'h4120_0000_0000_0000);
        next_cycle();

        // Abort after 2 of 4 words; the word offered with abort is refused
        start_load(1'b1, 1'b0, 3'd3);
        send_word(16'hAAAA);
        send_word(16'hBBBB);
        abort  = 1'b1;
        wvalid = 1'b1;
        wdata  = 16'hDEAD;
        #3;
        check("abort_wready", {63'd0, wready}, 64'd0);
        next_cycle();
        abort  = 1'b0;
        wvalid = 1'b0;
        #3;
        check("abort_idle", {63'd0, busy}, 64'd0);
        check("abort_no_we", {63'd0, we}, 64'd0);
        next_cycle();
        start_load(1'b0, 1'b0, 3'd1);
        send_word(16'h5555);
        send_word(16'h6666);
        expect_write(3'd1, 64'h5555_6666_0000_0000);

        // Abort in the WRITE cycle suppresses the strobe
        start_load(1'b0, 1'b0, 3'd4);
        send_word(16'h7777);
        send_word(16'h8888);
        abort = 1'b1;
        #3;
        check("abort_write_we", {63'd0, we}, 64'd0);
        check("abort_write_done", {63'd0, done}, 64'd0);
        next_cycle();
        abort = 1'b0;
        #3;
        check("abort_write_idle", {63'd0, busy}, 64'd0);
        next_cycle();

        // abort in IDLE blocks a simultaneous start
        abort = 1'b1;
        start = 1'b1;
        next_cycle();
        abort = 1'b0;
        start = 1'b0;
        #3;
        check("idle_abort_start", {63'd0, busy}, 64'd0);
        next_cycle();

        // Reset mid-COLLECT clears everything immediately
        start_load(1'b1, 1'b0, 3'd2);
        send_word(16'hAAAA);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // start while busy is ignored
        start_load(1'b0, 1'b0, 3'd3);
        send_word(16'h1234);
        start  = 1'b1;
        fpmode = 1'b1;
        dst    = 3'd0;
        send_word(16'h5678);
        start = 1'b0;
        expect_write(3'd3, 64'h1234_5678_0000_0000);
        for (int i = 0; i < 4; i++) begin
            #3;
            check("no_second_write", {63'd0, we}, 64'd0);
            check("no_second_busy", {63'd0, busy}, 64'd0);
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
